counter_checker: RTL and testbench

Self-checking monitor for the `Counter` DUT. It observes the counter's `enb`, `count` and `carryout` each clock and compares them against an internal reference model. It counts and records mismatches, and flags completion at the first wrap-around. It sits in the simulation top beside the DUT and replaces ad-hoc end-of-test logic with a `done`/`pass` verdict the scenario FSM can act on.

---
 rtl/counter_checker_pkg.sv | 19 +
 rtl/sat_counter.sv | 31 +++
 rtl/counter_checker.sv | 136 +++++++++++++
 tb/tb_counter_checker.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/counter_checker_pkg.sv
// Shared types and constants for the counter_checker monitor.
package counter_checker_pkg;

  localparam int unsigned ERR_COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    COUNT = 2'b01,
    CARRY = 2'b10,
    BOTH  = 2'b11
  } err_code_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; synchronous clear has priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned MAX   = 65535
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != MaxVal)) begin
      value_d = value_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/counter_checker.sv
// Reference-model monitor for a free-running WIDTH-bit counter with carry.
// Define COUNTER_CHECKER_LOG_EN to print per-error and end-of-run messages.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_ERRORS = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb,
  input  logic [WIDTH-1:0]       count,
  input  logic                   carryout,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_COUNT_W-1:0] err_count,
  output logic                   first_err_valid,
  output logic [WIDTH-1:0]       first_err_count,
  output logic [1:0]             first_err_code
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_count_q, exp_count_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fe_valid_q, fe_valid_d;
  logic [WIDTH-1:0] fe_count_q, fe_count_d;
  err_code_e        fe_code_q, fe_code_d;

  logic                   check_en;
  logic                   model_carry;
  logic                   cnt_bad;
  logic                   cy_bad;
  logic                   err;
  logic [ERR_COUNT_W-1:0] err_value;

  always_comb begin
    check_en    = (state_q != DONE);
    model_carry = enb && (exp_count_q == '1);
    cnt_bad     = (count != exp_count_q);
    cy_bad      = (carryout != model_carry);
    err         = check_en && (cnt_bad || cy_bad);

    state_d     = state_q;
    exp_count_d = exp_count_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fe_valid_d  = fe_valid_q;
    fe_count_d  = fe_count_q;
    fe_code_d   = fe_code_q;

    if (check_en && enb) begin
      exp_count_d = exp_count_q + 1'b1;
    end

    if (err && !fe_valid_q) begin
      fe_valid_d = 1'b1;
      fe_count_d = count;
      fe_code_d  = err_code_e'({cy_bad, cnt_bad});
    end

    case (state_q)
      IDLE: if (enb) state_d = RUN;
      RUN: begin
        if (model_carry) begin
          state_d = DONE;
          done_d  = 1'b1;
          // An error on the carry cycle itself must veto the verdict.
          pass_d  = (err_value == '0) && !err;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_count_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fe_valid_q  <= 1'b0;
      fe_count_q  <= '0;
      fe_code_q   <= NONE;
    end else begin
      state_q     <= state_d;
      exp_count_q <= exp_count_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fe_valid_q  <= fe_valid_d;
      fe_count_q  <= fe_count_d;
      fe_code_q   <= fe_code_d;
    end
  end

  sat_counter #(
    .WIDTH (ERR_COUNT_W),
    .MAX   (MAX_ERRORS)
  ) u_err_count (
    .clk   (clk),
    .clr   (rst),
    .inc   (err),
    .value (err_value)
  );

  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_value;
  assign first_err_valid = fe_valid_q;
  assign first_err_count = fe_count_q;
  assign first_err_code  = fe_code_q;

`ifdef COUNTER_CHECKER_LOG_EN
  logic log_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      log_done_q <= 1'b0;
    end else begin
      if (err) begin
        $display("%0t counter_checker: count=%0d carry=%0b expected count=%0d carry=%0b",
                 $time, count, carryout, exp_count_q, model_carry);
      end
      if (done_q && !log_done_q) begin
        log_done_q <= 1'b1;
        $display("%0t counter_checker: %s err_count=%0d", $time,
                 pass_q ? "PASS" : "FAIL", err_value);
      end
    end
  end
`else
  // Logging compiled out; registered behaviour is unchanged.
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Randomised and directed scoreboard bench for counter_checker at WIDTH=4, MAX_ERRORS=3.
module tb_counter_checker;

  localparam int unsigned W    = 4;
  localparam int unsigned MAXE = 3;
  localparam int          MOD  = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enb = 1'b0;
  logic [W-1:0] count = '0;
  logic         carryout = 1'b0;
  logic         done;
  logic         pass;
  logic [15:0]  err_count;
  logic         first_err_valid;
  logic [W-1:0] first_err_count;
  logic [1:0]   first_err_code;

  counter_checker #(
    .WIDTH      (W),
    .MAX_ERRORS (MAXE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enb             (enb),
    .count           (count),
    .carryout        (carryout),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_count (first_err_count),
    .first_err_code  (first_err_code)
  );

  always #5 clk = ~clk;

  typedef logic [24:0] obs_t;  // {done, pass, err_count, valid, first_count, first_code}
  obs_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Behavioural DUT under observation.
  int dut_cnt = 0;

  // Reference model state: enabled cycles seen since reset, and verdict fields.
  int n_en = 0;
  bit fin = 0, pass_m = 0, fv = 0;
  int errs = 0, fcnt = 0, fcode = 0;

  task automatic cycle(input bit r, input bit e, input int force_cnt, input int force_cy);
    int  cnt, exp_c;
    bit  cy, want_cy, cb, yb;
    obs_t o;
    @(negedge clk);
    cnt = (force_cnt >= 0) ? force_cnt : dut_cnt;
    cy  = (force_cy >= 0) ? force_cy[0] : (e && dut_cnt == MOD - 1);
    rst = r;
    enb = e;
    count = W'(cnt);
    carryout = cy;
    if (r) begin
      n_en = 0; fin = 0; pass_m = 0; errs = 0; fv = 0; fcnt = 0; fcode = 0;
    end else if (!fin) begin
      exp_c   = n_en % MOD;
      want_cy = e && (exp_c == MOD - 1);
      cb      = (cnt != exp_c);
      yb      = (cy != want_cy);
      if (cb || yb) begin
        if (errs < int'(MAXE)) errs++;
        if (!fv) begin
          fv = 1; fcnt = cnt; fcode = {30'd0, yb, cb};
        end
      end
      if (e) begin
        if (exp_c == MOD - 1) begin
          fin = 1;
          pass_m = (errs == 0);
        end
        n_en++;
      end
    end
    o = {fin, pass_m, 16'(errs), fv, W'(fcnt), 2'(fcode)};
    exp_q.push_back(o);
    if (r) dut_cnt = 0;
    else if (e) dut_cnt = (dut_cnt + 1) % MOD;
  endtask

  task automatic do_reset();
    cycle(1, 0, -1, -1);
    cycle(1, 0, -1, -1);
  endtask

  task automatic run_en(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, -1, -1);
  endtask

  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {done, pass, err_count, first_err_valid, first_err_count, first_err_code};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got done=%b pass=%b errs=%0d fv=%b fcnt=%0d fcode=%b want done=%b pass=%b errs=%0d fv=%b fcnt=%0d fcode=%b",
                 $time, a[24], a[23], a[22:7], a[6], a[5:2], a[1:0],
                 e[24], e[23], e[22:7], e[6], e[5:2], e[1:0]);
      end
    end
  end

  initial begin
    // Clean run, then idle cycles with done held.
    do_reset();
    run_en(16);
    for (int i = 0; i < 3; i++) cycle(0, 0, -1, -1);

    // enb toggling.
    do_reset();
    for (int i = 0; i < 34; i++) cycle(0, i[0] == 1'b0, -1, -1);

    // Count 7 reported where 5 expected.
    do_reset();
    run_en(5);
    cycle(0, 1, 7, -1);
    run_en(12);
    cycle(0, 0, -1, -1);

    // Carry suppressed at 15.
    do_reset();
    run_en(15);
    cycle(0, 1, -1, 0);
    cycle(0, 0, -1, -1);

    // Count and carry both wrong on one cycle.
    do_reset();
    run_en(5);
    cycle(0, 1, 3, 1);
    run_en(12);

    // Count stuck at 0: err_count saturates.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0);

    // Reset mid-run at count 9, then a clean run.
    do_reset();
    run_en(9);
    cycle(1, 0, -1, -1);
    run_en(16);
    cycle(0, 0, -1, -1);

    // Random traffic with occasional faults and resets.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bit r, e;
      int fc, fy;
      r  = ($urandom_range(0, 63) == 0);
      e  = $urandom_range(0, 3) != 0;
      fc = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, MOD - 1)) : -1;
      fy = ($urandom_range(0, 23) == 0) ? int'($urandom_range(0, 1)) : -1;
      cycle(r, e, fc, fy);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
